gpio_ctrl_n: RTL and testbench

- Parametrised successor to the fixed 8-pin GPIO slave on the RIB bus.
- Provides NUM_IO pins, each with per-pin direction, output data, synchronised input, and edge-triggered interrupt with W1C pending bits.
- Tristate buffers stay at SoC top, driven by io_o/io_oe_o.
- Sits as one RIB slave; int_o feeds one bit of the core int_i vector.

---
 rtl/gpio_ctrl_n_pkg.sv | 23 ++
 rtl/gpio_pin_filter.sv | 58 +++++
 rtl/gpio_ctrl_n.sv | 144 ++++++++++++++
 tb/tb_gpio_ctrl_n.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_n_pkg.sv
// Shared register offsets, bus handshake state encoding and byte-lane helper for gpio_ctrl_n.
package gpio_ctrl_n_pkg;

  // Word offsets, decoded from addr_i[4:2]
  localparam logic [2:0] GPIO_DIR     = 3'd0;
  localparam logic [2:0] GPIO_OUT     = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_RISE_IE = 3'd3;
  localparam logic [2:0] GPIO_FALL_IE = 3'd4;
  localparam logic [2:0] GPIO_IP      = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin input conditioning: SYNC_STAGES-deep synchroniser, then an optional
// debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_pin_filter
  import gpio_ctrl_n_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic io_i,
  output logic filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], io_i};
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // Any return to the filtered level restarts the stability count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) filt_d = sync_q[SYNC_STAGES-1];
      else                                    cnt_d  = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign filt_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_ctrl_n.sv
// Parametrised GPIO slave on the RIB bus: direction/output registers, filtered inputs,
// edge interrupts with W1C pending bits. Optional debounce via GPIO_DEBOUNCE_EN.
module gpio_ctrl_n
  import gpio_ctrl_n_pkg::*;
#(
  parameter int unsigned NUM_IO          = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_i,
  output logic [NUM_IO-1:0] io_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic              int_o
);

  bus_state_e state_q, state_d;

  logic [NUM_IO-1:0] dir_q, dir_d, out_q, out_d;
  logic [NUM_IO-1:0] rise_ie_q, rise_ie_d, fall_ie_q, fall_ie_d;
  logic [NUM_IO-1:0] ip_q, ip_d, ip_clr, edge_set;
  logic [NUM_IO-1:0] in_q, in_filt;
  logic [NUM_IO-1:0] wmask_n, wbits;
  logic [31:0]       wmask32, rd_data, data_q;
  logic              int_q, accept, wr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_pin
      gpio_pin_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
        .clk   (clk),
        .rst   (rst),
        .io_i  (io_i[gi]),
        .filt_o(in_filt[gi])
      );
    end
  endgenerate

  // Upper address bits and data/lane bits above NUM_IO are architecturally ignored.
  logic unused_bus;
  assign unused_bus = ^{addr_i[31:5], addr_i[1:0], data_i, wmask32};

  assign wmask32 = lane_mask(sel_i);
  assign wmask_n = wmask32[NUM_IO-1:0];
  assign wbits   = data_i[NUM_IO-1:0] & wmask_n;
  assign accept  = req_valid_i & req_ready_o;
  assign wr      = accept & we_i;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_ie_d = rise_ie_q;
    fall_ie_d = fall_ie_q;
    ip_clr    = '0;
    if (wr) begin
      case (addr_i[4:2])
        GPIO_DIR:     dir_d     = (dir_q & ~wmask_n) | wbits;
        GPIO_OUT:     out_d     = (out_q & ~wmask_n) | wbits;
        GPIO_RISE_IE: rise_ie_d = (rise_ie_q & ~wmask_n) | wbits;
        GPIO_FALL_IE: fall_ie_d = (fall_ie_q & ~wmask_n) | wbits;
        GPIO_IP:      ip_clr    = wbits;
        GPIO_OUT_SET: out_d     = out_q | wbits;
        GPIO_OUT_CLR: out_d     = out_q & ~wbits;
        default: ;
      endcase
    end
    // New edges are OR'd in after the clear so a same-cycle edge wins.
    edge_set = (in_filt & ~in_q & rise_ie_q) | (~in_filt & in_q & fall_ie_q);
    ip_d     = (ip_q & ~ip_clr) | edge_set;
  end

  always_comb begin
    rd_data = '0;
    case (addr_i[4:2])
      GPIO_DIR:     rd_data = 32'(dir_q);
      GPIO_OUT:     rd_data = 32'(out_q);
      GPIO_IN:      rd_data = 32'(in_filt);
      GPIO_RISE_IE: rd_data = 32'(rise_ie_q);
      GPIO_FALL_IE: rd_data = 32'(fall_ie_q);
      GPIO_IP:      rd_data = 32'(ip_q);
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= '0;
      out_q     <= '0;
      rise_ie_q <= '0;
      fall_ie_q <= '0;
      ip_q      <= '0;
      in_q      <= '0;
      int_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_ie_q <= rise_ie_d;
      fall_ie_q <= fall_ie_d;
      ip_q      <= ip_d;
      in_q      <= in_filt;
      int_q     <= |ip_q;
      if (accept) data_q <= rd_data;
    end
  end

  assign io_o    = out_q;
  assign io_oe_o = dir_q;
  assign int_o   = int_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_gpio_ctrl_n.sv
// Directed-vector bench for gpio_ctrl_n: register access, set/clear aliases, edge interrupts,
// response back-pressure and reset mid-transaction; debounce checks when GPIO_DEBOUNCE_EN is set.
module tb_gpio_ctrl_n;

  localparam int NIO = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int IN_LAT = 2 + 4;
`else
  localparam int IN_LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    addr_i = '0, data_i = '0;
  logic [3:0]     sel_i = '0;
  logic           we_i = 1'b0, req_valid_i = 1'b0, rsp_ready_i = 1'b1;
  logic           req_ready_o, rsp_valid_o, int_o;
  logic [31:0]    data_o;
  logic [NIO-1:0] io_i = '0, io_o, io_oe_o;

  logic [31:0]    rdata;
  logic [NIO-1:0] snap_o, snap_oe;
  int             nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  gpio_ctrl_n #(.NUM_IO(NIO), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .data_o(data_o), .io_i(io_i), .io_o(io_o),
    .io_oe_o(io_oe_o), .int_o(int_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction; snapshots outputs one cycle after the commit edge.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input logic we, output logic [31:0] rd);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready_o) check_eq("req_ready_timeout", {31'b0, req_ready_o}, 32'd1);
    addr_i = addr; data_i = wdata; sel_i = sel; we_i = we; req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    we_i = 1'b0;
    rd = data_o;
    snap_o = io_o;
    snap_oe = io_oe_o;
    check_eq("rsp_valid_after_accept", {31'b0, rsp_valid_o}, 32'd1);
    guard = 0;
    while (rsp_valid_o && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (rsp_valid_o) check_eq("rsp_complete_timeout", {31'b0, rsp_valid_o}, 32'd0);
    $display("%s addr=0x%02h wdata=0x%08h sel=%b rdata=0x%08h",
             we ? "WR" : "RD", addr[7:0], wdata, sel, rd);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    logic [31:0] dummy;
    bus_xfer(addr, wdata, sel, 1'b1, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    bus_xfer(addr, 32'h0, 4'h0, 1'b0, got);
    check_eq(tag, got, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_io_oe", 32'(io_oe_o), 32'h0);
    check_eq("rst_io_o", 32'(io_o), 32'h0);
    check_eq("rst_int", {31'b0, int_o}, 32'h0);
    check_eq("rst_req_ready", {31'b0, req_ready_o}, 32'h1);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check_eq("rst_data_o", data_o, 32'h0);
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_read_%0h", a * 4), 32'(a * 4), 32'h0);

    // Byte lanes and bits above NUM_IO
    wr(32'h00, 32'h0000_00FF, 4'b0001);
    check_eq("dir_oe_after_commit", 32'(snap_oe), 32'h00FF);
    wr(32'h00, 32'hFFFF_FFFF, 4'b1100);
    rd_chk("dir_upper_lanes_ignored", 32'h00, 32'h0000_00FF);
    wr(32'h00, 32'hFFFF_0000, 4'b0010);
    rd_chk("dir_lane1_clear_ignored", 32'h00, 32'h0000_00FF);
    wr(32'h04, 32'h0000_A5A5, 4'b1111);
    check_eq("out_io_after_commit", 32'(snap_o), 32'hA5A5);
    rd_chk("out_read", 32'h04, 32'h0000_A5A5);
    wr(32'h08, 32'h0000_FFFF, 4'b1111);
    rd_chk("in_ro_write_ignored", 32'h08, 32'h0);

    // Set/clear aliases
    wr(32'h04, 32'h0, 4'b1111);
    wr(32'h18, 32'h0000_0003, 4'b1111);
    check_eq("out_set_io", 32'(snap_o), 32'h0003);
    wr(32'h1C, 32'h0000_0001, 4'b1111);
    rd_chk("out_after_set_clr", 32'h04, 32'h0000_0002);
    rd_chk("out_set_reads0", 32'h18, 32'h0);
    rd_chk("out_clr_reads0", 32'h1C, 32'h0);

    // Rising-edge interrupt on pin 4, exact latency to int_o
    wr(32'h0C, 32'h0000_0010, 4'b1111);
    @(negedge clk);
    io_i[4] = 1'b1;
    repeat (IN_LAT + 1) @(posedge clk);
    #1;
    check_eq("int_not_yet", {31'b0, int_o}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("int_rise_set", {31'b0, int_o}, 32'h1);
    rd_chk("in_pin4", 32'h08, 32'h0000_0010);
    rd_chk("ip_pin4", 32'h14, 32'h0000_0010);
    @(negedge clk);
    io_i[4] = 1'b0;
    repeat (IN_LAT + 4) @(posedge clk);
    rd_chk("fall_no_ie_ip_kept", 32'h14, 32'h0000_0010);
    wr(32'h14, 32'h0000_0010, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    check_eq("int_cleared", {31'b0, int_o}, 32'h0);
    rd_chk("ip_cleared", 32'h14, 32'h0);

    // Falling edge on an output-configured pin; IE clear does not clear IP
    wr(32'h10, 32'h0000_0020, 4'b1111);
    @(negedge clk);
    io_i[5] = 1'b1;
    repeat (IN_LAT + 4) @(posedge clk);
    rd_chk("rise_no_ie_no_ip", 32'h14, 32'h0);
    @(negedge clk);
    io_i[5] = 1'b0;
    repeat (IN_LAT + 4) @(posedge clk);
    rd_chk("ip_pin5_fall", 32'h14, 32'h0000_0020);
    wr(32'h10, 32'h0, 4'b1111);
    rd_chk("ie_clear_keeps_ip", 32'h14, 32'h0000_0020);
    wr(32'h14, 32'h0000_0020, 4'b0000);
    rd_chk("w1c_no_lane_ignored", 32'h14, 32'h0000_0020);
    wr(32'h14, 32'h0000_0020, 4'b0001);
    rd_chk("w1c_lane0", 32'h14, 32'h0);

    // Response back-pressure with a second request waiting
    rsp_ready_i = 1'b0;
    @(negedge clk);
    addr_i = 32'h00; we_i = 1'b0; sel_i = 4'h0; req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    we_i = 1'b1; data_i = 32'h0; sel_i = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("hold_rsp_valid_%0d", c), {31'b0, rsp_valid_o}, 32'h1);
      check_eq($sformatf("hold_data_%0d", c), data_o, 32'h0000_00FF);
      check_eq($sformatf("hold_req_ready_%0d", c), {31'b0, req_ready_o}, 32'h0);
    end
    check_eq("hold_write_blocked", 32'(io_oe_o), 32'h00FF);
    @(negedge clk);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    we_i = 1'b0;
    check_eq("queued_write_committed", 32'(io_oe_o), 32'h0);
    $display("RD addr=0x00 held 5 cycles, queued WR DIR=0x00000000");
    @(posedge clk);
    #1;

    // Reset while a response is pending
    rsp_ready_i = 1'b0;
    @(negedge clk);
    addr_i = 32'h04; we_i = 1'b0; req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check_eq("midrst_io_o", 32'(io_o), 32'h0);
    rst = 1'b0;
    rsp_ready_i = 1'b1;
    $display("RD addr=0x04 dropped by reset");
    rd_chk("post_rst_out", 32'h04, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    wr(32'h0C, 32'h0000_0001, 4'b1111);
    wr(32'h10, 32'h0000_0001, 4'b1111);
    @(negedge clk);
    io_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    io_i[0] = 1'b0;
    repeat (20) @(negedge clk);
    rd_chk("glitch_in", 32'h08, 32'h0);
    rd_chk("glitch_ip", 32'h14, 32'h0);
    @(negedge clk);
    io_i[0] = 1'b1;
    repeat (6) @(negedge clk);
    io_i[0] = 1'b0;
    repeat (20) @(negedge clk);
    rd_chk("pulse_in_back_low", 32'h08, 32'h0);
    rd_chk("pulse_ip", 32'h14, 32'h0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected completion");
    $fatal(1, "timeout");
  end

endmodule
